// File: rtl/mcl_axil_rx_fifo_chain.sv
// mcl_axil_rx_fifo_chain
//   Host-to-AXI-Lite request RX path. A wide host word is split into ratio_lp narrow beats,
//   least-significant slice first. The beats go into an els_lp-deep 1r1w FIFO, and the number
//   of free FIFO slots is reported to the host as a credit count.
//
// Ports
//   clk_i            rising-edge clock
//   reset_i          synchronous active-high reset; clears all state
//   fifo_req_i       wide request word
//   fifo_req_v_i     wide word valid
//   fifo_req_ready_o wide word accepted when valid & ready
//   axil_req_o       narrow beat at the FIFO head (don't-care when not valid)
//   axil_req_v_o     FIFO non-empty
//   axil_req_ready_i consumer ready; pop = axil_req_v_o & axil_req_ready_i
//   req_credits_o    free FIFO entries, 0..els_lp
//
// Build option
//   MCL_RX_FIFO_ASSERT_EN: adds simulation-only parameter and runtime checks. It does not
//   change functional behaviour.
module mcl_axil_rx_fifo_chain #(
  parameter int unsigned host_width_p = 128,
  parameter int unsigned axil_width_p = 32,
  parameter int unsigned credits_p    = 4,
  localparam int unsigned ratio_lp     = host_width_p / axil_width_p,
  localparam int unsigned els_lp       = ratio_lp * credits_p,
  localparam int unsigned cnt_width_lp = $clog2(els_lp + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [host_width_p-1:0] fifo_req_i,
  input  logic                    fifo_req_v_i,
  output logic                    fifo_req_ready_o,
  output logic [axil_width_p-1:0] axil_req_o,
  output logic                    axil_req_v_o,
  input  logic                    axil_req_ready_i,
  output logic [cnt_width_lp-1:0] req_credits_o
);

  localparam int unsigned IdxW = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
  localparam int unsigned PtrW = (els_lp > 1) ? $clog2(els_lp) : 1;

  // ---------------------------------------------------------------------------
  // PISO: holding register plus slice index
  // ---------------------------------------------------------------------------
  logic [host_width_p-1:0] piso_data_q;
  logic [IdxW-1:0]         piso_idx_q, piso_idx_d;
  logic                    piso_full_q, piso_full_d;
  logic                    piso_last;
  logic [axil_width_p-1:0] piso_beat;
  logic                    accept;

  // FIFO side signals used by the PISO
  logic                    push, pop;
  logic                    fifo_full_q, fifo_full_d;
  logic                    fifo_empty_q, fifo_empty_d;

  assign piso_last = (piso_idx_q == IdxW'(ratio_lp - 1));
  assign piso_beat = piso_data_q[piso_idx_q * axil_width_p +: axil_width_p];

  // A slice moves into the FIFO whenever one is held and the FIFO has room.
  assign push = piso_full_q & ~fifo_full_q;

  // Ready also in the cycle the last slice leaves, so back-to-back words stream without a bubble.
  assign fifo_req_ready_o = ~piso_full_q | (push & piso_last);
  assign accept           = fifo_req_v_i & fifo_req_ready_o;

  always_comb begin
    piso_idx_d  = piso_idx_q;
    piso_full_d = piso_full_q;
    if (accept) begin
      piso_full_d = 1'b1;
      piso_idx_d  = '0;
    end else if (push) begin
      if (piso_last) begin
        piso_full_d = 1'b0;
      end else begin
        piso_idx_d = piso_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      piso_full_q <= 1'b0;
      piso_idx_q  <= '0;
    end else begin
      piso_full_q <= piso_full_d;
      piso_idx_q  <= piso_idx_d;
    end
  end

  // Data carries no reset; it is only observed while piso_full_q is set.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      piso_data_q <= fifo_req_i;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO: circular buffer, depth need not be a power of two
  // ---------------------------------------------------------------------------
  logic [axil_width_p-1:0] mem_q [els_lp];
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(els_lp - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop          = ~fifo_empty_q & axil_req_ready_i;
  assign axil_req_v_o = ~fifo_empty_q;
  assign axil_req_o   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_full_d  = fifo_full_q;
    fifo_empty_d = fifo_empty_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop) begin
      fifo_empty_d = 1'b0;
      fifo_full_d  = (ptr_inc(wr_ptr_q) == rd_ptr_q);
    end else if (pop && !push) begin
      fifo_full_d  = 1'b0;
      fifo_empty_d = (ptr_inc(rd_ptr_q) == wr_ptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_full_q  <= 1'b0;
      fifo_empty_q <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_full_q  <= fifo_full_d;
      fifo_empty_q <= fifo_empty_d;
    end
  end

  // No write-to-read bypass: a pushed beat becomes visible the following cycle.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= piso_beat;
    end
  end

  // ---------------------------------------------------------------------------
  // Credits: free entries, registered
  // ---------------------------------------------------------------------------
  logic [cnt_width_lp-1:0] credits_q, credits_d;

  always_comb begin
    credits_d = credits_q;
    unique case ({push, pop})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credits_q <= cnt_width_lp'(els_lp);
    end else begin
      credits_q <= credits_d;
    end
  end

  assign req_credits_o = credits_q;

`ifdef MCL_RX_FIFO_ASSERT_EN
  if (ratio_lp * axil_width_p != host_width_p) begin : g_chk_ratio
    $fatal(1, "host_width_p must be an integer multiple of axil_width_p");
  end
  if (credits_p == 0) begin : g_chk_credits
    $fatal(1, "credits_p must be non-zero");
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (push && fifo_full_q)  $error("push while FIFO full");
      if (pop && fifo_empty_q)  $error("pop while FIFO empty");
      if (credits_q > cnt_width_lp'(els_lp)) $error("credits out of range: %0d", credits_q);
    end
  end
`endif

endmodule

// File: tb/tb_mcl_axil_rx_fifo_chain.sv
module tb_mcl_axil_rx_fifo_chain;

  localparam int unsigned HostW = 128;
  localparam int unsigned AxilW = 32;
  localparam int unsigned Ratio = HostW / AxilW;
  localparam int unsigned Els   = Ratio * 4;
  localparam int unsigned CntW  = $clog2(Els + 1);

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [HostW-1:0] fifo_req_i;
  logic             fifo_req_v_i;
  logic             fifo_req_ready_o;
  logic [AxilW-1:0] axil_req_o;
  logic             axil_req_v_o;
  logic             axil_req_ready_i;
  logic [CntW-1:0]  req_credits_o;

  mcl_axil_rx_fifo_chain dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .fifo_req_i       (fifo_req_i),
    .fifo_req_v_i     (fifo_req_v_i),
    .fifo_req_ready_o (fifo_req_ready_o),
    .axil_req_o       (axil_req_o),
    .axil_req_v_o     (axil_req_v_o),
    .axil_req_ready_i (axil_req_ready_i),
    .req_credits_o    (req_credits_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Reference model: slices still waiting in the serializer, beats stored in the buffer,
  // and the expected beat order across all accepted words.
  int               pend = 0;
  int               occ  = 0;
  logic [AxilW-1:0] expq [$];
  logic [HostW-1:0] cur_word;
  int               acc_cnt = 0;
  int               cyc     = 0;
  int               first_v, last_v, v_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [HostW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input logic rst, input logic v, input logic rdy);
    logic m_push, m_pop, m_ready;
    logic [AxilW-1:0] exp_beat;
    @(negedge clk_i);
    reset_i          = rst;
    fifo_req_v_i     = v;
    fifo_req_i       = cur_word;
    axil_req_ready_i = rdy;
    #1;
    m_push  = (pend > 0) && (occ < Els);
    m_pop   = (occ > 0) && rdy;
    m_ready = (pend == 0) || (m_push && pend == 1);
    check("ready_o", 32'(fifo_req_ready_o), 32'(m_ready));
    check("req_v_o", 32'(axil_req_v_o), 32'(occ > 0));
    check("credits", 32'(req_credits_o), 32'(Els - occ));
    if (axil_req_v_o) begin
      if (last_v == cyc - 1 || v_cnt == 0) v_cnt++;
      if (v_cnt == 1) first_v = cyc;
      last_v = cyc;
    end
    if (m_pop) begin
      exp_beat = expq.pop_front();
      check("beat", axil_req_o, exp_beat);
    end
    if (rst) begin
      occ  = 0;
      pend = 0;
      expq.delete();
    end else begin
      occ  = occ + int'(m_push) - int'(m_pop);
      pend = pend - int'(m_push);
      if (v && m_ready) begin
        for (int k = 0; k < Ratio; k++) expq.push_back(cur_word[k*AxilW +: AxilW]);
        pend     = pend + Ratio;
        acc_cnt  = acc_cnt + 1;
        cur_word = rand_word();
      end
    end
    cyc++;
  endtask

  initial begin
    reset_i          = 1'b1;
    fifo_req_v_i     = 1'b0;
    fifo_req_i       = '0;
    axil_req_ready_i = 1'b0;
    cur_word         = rand_word();
    v_cnt            = 0;
    first_v          = 0;
    last_v           = 0;

    // Reset and idle
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

    // Single directed word, consumer always ready
    cur_word = 128'h44444444_33333333_22222222_11111111;
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);
    check("drained", 32'(req_credits_o), 32'(Els));

    // Consumer stalled: fill the buffer, then keep a word pending
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 1'b0);
    check("full_credits", 32'(req_credits_o), 32'd0);
    // Release the consumer with the input still streaming
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1);

    // Back-to-back pair of words: 8 beats in 8 consecutive cycles
    acc_cnt = 0;
    v_cnt   = 0;
    for (int i = 0; i < 14; i++) step(1'b0, acc_cnt < 2, 1'b1);
    check("b2b_beats", 32'(v_cnt), 32'd8);
    check("b2b_span", 32'(last_v - first_v + 1), 32'd8);

    // Reset with beats buffered and the serializer loaded
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1);
    check("final_credits", 32'(req_credits_o), 32'(Els));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
